// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared definitions for the CP0 exception sequencer: flag levels,
// sequencer states and the Cause.ExcCode values it can raise.
package cp0_exc_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_COMMIT,
    S_REDIRECT,
    S_ERET_RET
  } exc_state_t;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/cp0_exc_ctrl_addr_align_check.sv
// Combinational misalignment detection for instruction fetch and data
// access, plus the address that BadVAddr should capture.
module addr_align_check
  import cp0_exc_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic        half,
  output logic        fetch_mis,
  output logic        load_mis,
  output logic        store_mis,
  output logic [31:0] fault_addr
);

  logic data_mis;

  // Byte accesses never misalign; halfwords need bit 0 clear, words bits 1:0.
  always_comb begin
    fetch_mis  = (pc[1:0] != 2'b00);
    data_mis   = half ? addr[0] : (addr[1:0] != 2'b00);
    load_mis   = rd & data_mis;
    store_mis  = wr & ~rd & data_mis;
    fault_addr = fetch_mis ? pc : addr;
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception sequencer driving the CP0 write side, pipeline flush/stall and
// PC redirect. Optional macro CP0_EXC_DELAY_SLOT_EN adds branch-delay-slot
// handling (in_delay_slot input, cause_bd output).
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_mem,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_half,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        eret,
  input  logic        int_pending,
  input  logic        status_exl,
  input  logic [31:0] epc_in,
`ifdef CP0_EXC_DELAY_SLOT_EN
  input  logic        in_delay_slot,
  output logic        cause_bd,
`endif
  output logic        addr_err,
  output logic [31:0] badvaddr_p,
  output logic        epc_w,
  output logic [31:0] epc_p,
  output logic        cause_w,
  output logic [4:0]  exc_code,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        flush,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc
);

  exc_state_t  state, state_nxt;
  logic        fetch_mis, load_mis, store_mis;
  logic [31:0] fault_addr;
  logic        exc_take, eret_take, det_adr;
  logic [4:0]  det_code;
  logic [31:0] det_epc;

  logic [4:0]  pend_code;
  logic [31:0] pend_badv, pend_epc;
  logic        pend_adr, pend_epc_we;
  logic [31:0] badv_r, epc_r, redir_r;
  logic [4:0]  code_r;
`ifdef CP0_EXC_DELAY_SLOT_EN
  logic        pend_bd, bd_r;
`endif

  addr_align_check u_align (
    .pc         (pc_mem),
    .addr       (mem_addr),
    .rd         (mem_rd),
    .wr         (mem_wr),
    .half       (mem_half),
    .fetch_mis  (fetch_mis),
    .load_mis   (load_mis),
    .store_mis  (store_mis),
    .fault_addr (fault_addr)
  );

  // Prioritised exception detection; ERET only when no exception competes.
  always_comb begin
    exc_take = DISABLE;
    det_adr  = DISABLE;
    det_code = EXC_INT;
    if (mem_valid) begin
      if (int_pending && !status_exl) begin
        exc_take = ENABLE;  det_code = EXC_INT;
      end else if (fetch_mis) begin
        exc_take = ENABLE;  det_code = EXC_ADEL; det_adr = ENABLE;
      end else if (exc_ri) begin
        exc_take = ENABLE;  det_code = EXC_RI;
      end else if (exc_sys) begin
        exc_take = ENABLE;  det_code = EXC_SYS;
      end else if (exc_bp) begin
        exc_take = ENABLE;  det_code = EXC_BP;
      end else if (exc_ov) begin
        exc_take = ENABLE;  det_code = EXC_OV;
      end else if (load_mis) begin
        exc_take = ENABLE;  det_code = EXC_ADEL; det_adr = ENABLE;
      end else if (store_mis) begin
        exc_take = ENABLE;  det_code = EXC_ADES; det_adr = ENABLE;
      end
    end
    eret_take = mem_valid & eret & ~exc_take;
`ifdef CP0_EXC_DELAY_SLOT_EN
    det_epc = in_delay_slot ? (pc_mem - 32'd4) : pc_mem;
`else
    det_epc = pc_mem;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and one-cycle strobes decoded from the current state.
  always_comb begin
    state_nxt   = state;
    flush       = 1'b0;
    stall       = 1'b0;
    cause_w     = 1'b0;
    exl_set     = 1'b0;
    exl_clr     = 1'b0;
    addr_err    = 1'b0;
    epc_w       = 1'b0;
    pc_redirect = 1'b0;
    case (state)
      S_IDLE: begin
        if (exc_take)       state_nxt = S_FLUSH;
        else if (eret_take) state_nxt = S_ERET_RET;
      end
      S_FLUSH: begin
        flush     = 1'b1;
        stall     = 1'b1;
        state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        stall     = 1'b1;
        cause_w   = 1'b1;
        exl_set   = 1'b1;
        addr_err  = pend_adr;
        epc_w     = pend_epc_we;
        state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        stall       = 1'b1;
        pc_redirect = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_ERET_RET: begin
        flush       = 1'b1;
        exl_clr     = 1'b1;
        pc_redirect = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture at detection, publish on entry to COMMIT so the visible buses
  // only change alongside their write strobes and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_code   <= '0;
      pend_badv   <= '0;
      pend_epc    <= '0;
      pend_adr    <= 1'b0;
      pend_epc_we <= 1'b0;
      badv_r      <= '0;
      epc_r       <= '0;
      code_r      <= '0;
      redir_r     <= '0;
`ifdef CP0_EXC_DELAY_SLOT_EN
      pend_bd     <= 1'b0;
      bd_r        <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && exc_take) begin
        pend_code   <= det_code;
        pend_badv   <= fault_addr;
        pend_epc    <= det_epc;
        pend_adr    <= det_adr;
        pend_epc_we <= ~status_exl;
`ifdef CP0_EXC_DELAY_SLOT_EN
        pend_bd     <= in_delay_slot;
`endif
      end
      if (state == S_IDLE && eret_take) redir_r <= epc_in;
      if (state == S_FLUSH) begin
        code_r <= pend_code;
        if (pend_adr)    badv_r <= pend_badv;
        if (pend_epc_we) epc_r  <= pend_epc;
`ifdef CP0_EXC_DELAY_SLOT_EN
        bd_r   <= pend_bd;
`endif
      end
      if (state == S_COMMIT) redir_r <= EXC_VECTOR;
    end
  end

  assign badvaddr_p  = badv_r;
  assign epc_p       = epc_r;
  assign exc_code    = code_r;
  assign redirect_pc = redir_r;
`ifdef CP0_EXC_DELAY_SLOT_EN
  assign cause_bd    = bd_r;
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl. Honours
// CP0_EXC_DELAY_SLOT_EN when defined.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_mem, mem_addr, epc_in;
  logic        mem_valid, mem_rd, mem_wr, mem_half;
  logic        exc_sys, exc_bp, exc_ri, exc_ov, eret, int_pending, status_exl;
  logic        addr_err, epc_w, cause_w, exl_set, exl_clr, flush, stall, pc_redirect;
  logic [31:0] badvaddr_p, epc_p, redirect_pc;
  logic [4:0]  exc_code;
`ifdef CP0_EXC_DELAY_SLOT_EN
  logic        in_delay_slot, cause_bd;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.EXC_VECTOR(32'hBFC0_0380)) dut (
    .clk(clk), .rst(rst), .pc_mem(pc_mem), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_half(mem_half),
    .exc_sys(exc_sys), .exc_bp(exc_bp), .exc_ri(exc_ri), .exc_ov(exc_ov),
    .eret(eret), .int_pending(int_pending), .status_exl(status_exl),
    .epc_in(epc_in),
`ifdef CP0_EXC_DELAY_SLOT_EN
    .in_delay_slot(in_delay_slot), .cause_bd(cause_bd),
`endif
    .addr_err(addr_err), .badvaddr_p(badvaddr_p), .epc_w(epc_w), .epc_p(epc_p),
    .cause_w(cause_w), .exc_code(exc_code), .exl_set(exl_set), .exl_clr(exl_clr),
    .flush(flush), .stall(stall), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clr_in;
    mem_valid = 0; mem_rd = 0; mem_wr = 0; mem_half = 0; mem_addr = '0;
    exc_sys = 0; exc_bp = 0; exc_ri = 0; exc_ov = 0; eret = 0;
    int_pending = 0; status_exl = 0; pc_mem = '0; epc_in = '0;
`ifdef CP0_EXC_DELAY_SLOT_EN
    in_delay_slot = 0;
`endif
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"},
          {24'd0, addr_err, epc_w, cause_w, exl_set, exl_clr, flush, stall, pc_redirect}, 32'd0);
    check({tag, "_badv"}, badvaddr_p, 32'd0);
    check({tag, "_epc"}, epc_p, 32'd0);
    check({tag, "_code"}, {27'd0, exc_code}, 32'd0);
    check({tag, "_rpc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    clr_in();
    rst = 1;
    step(); step();
    check_all_zero("reset");
    rst = 0;

    // 1: word load at 0xF -> AdEL
    mem_valid = 1; mem_rd = 1; mem_addr = 32'h0000_000F; pc_mem = 32'h0000_0100;
    step(); clr_in();
    check("t1_flush", {30'd0, flush, stall}, 32'h3);
    check("t1_n1_causew", {31'd0, cause_w}, 32'd0);
    step();
    check("t1_adderr", {31'd0, addr_err}, 32'd1);
    check("t1_badv", badvaddr_p, 32'h0000_000F);
    check("t1_code", {27'd0, exc_code}, 32'd4);
    check("t1_commit", {28'd0, cause_w, exl_set, epc_w, stall}, 32'hF);
    check("t1_epc", epc_p, 32'h0000_0100);
    step();
    check("t1_redir", {29'd0, pc_redirect, stall, addr_err}, 32'h6);
    check("t1_rpc", redirect_pc, 32'hBFC0_0380);
    step();
    check("t1_idle", {30'd0, pc_redirect, stall}, 32'd0);
    check("t1_badv_hold", badvaddr_p, 32'h0000_000F);

    // 2: halfword store, aligned then misaligned
    mem_valid = 1; mem_wr = 1; mem_half = 1; mem_addr = 32'h1000_0002; pc_mem = 32'h104;
    step(); clr_in();
    check("t2_aligned", {30'd0, flush, stall}, 32'd0);
    mem_valid = 1; mem_wr = 1; mem_half = 1; mem_addr = 32'h1000_0003; pc_mem = 32'h108;
    step(); clr_in();
    step();
    check("t2_code", {27'd0, exc_code}, 32'd5);
    check("t2_adderr", {31'd0, addr_err}, 32'd1);
    check("t2_badv", badvaddr_p, 32'h1000_0003);
    step(); step();

    // 3: overflow outranks misaligned load
    mem_valid = 1; mem_rd = 1; exc_ov = 1; mem_addr = 32'h2; pc_mem = 32'h200;
    step(); clr_in();
    step();
    check("t3_code", {27'd0, exc_code}, 32'd12);
    check("t3_adderr", {31'd0, addr_err}, 32'd0);
    check("t3_epc", epc_p, 32'h200);
    check("t3_badv_hold", badvaddr_p, 32'h1000_0003);
    step(); step();

    // 4: nested syscall keeps EPC; masked interrupt does nothing
    mem_valid = 1; exc_sys = 1; status_exl = 1; pc_mem = 32'h300;
    step(); clr_in();
    step();
    check("t4_strobes", {29'd0, epc_w, cause_w, exl_set}, 32'h3);
    check("t4_code", {27'd0, exc_code}, 32'd8);
    check("t4_epc_hold", epc_p, 32'h200);
    step(); step();
    mem_valid = 1; int_pending = 1; status_exl = 1; pc_mem = 32'h304;
    step(); clr_in();
    check("t4_int_masked", {29'd0, flush, stall, pc_redirect}, 32'd0);

    // Priority: interrupt over fetch AdEL, fetch AdEL over RI
    mem_valid = 1; int_pending = 1; exc_ri = 1; pc_mem = 32'h402;
    step(); clr_in(); step();
    check("pri_int", {27'd0, exc_code}, 32'd0);
    check("pri_int_adderr", {31'd0, addr_err}, 32'd0);
    step(); step();
    mem_valid = 1; exc_ri = 1; pc_mem = 32'h402;
    step(); clr_in(); step();
    check("pri_fetch", {27'd0, exc_code}, 32'd4);
    check("pri_fetch_badv", badvaddr_p, 32'h402);
    step(); step();

    // 5: ERET, then ERET colliding with break
    mem_valid = 1; eret = 1; epc_in = 32'h8000_0100;
    step(); clr_in();
    check("t5_eret", {28'd0, pc_redirect, exl_clr, flush, stall}, 32'hE);
    check("t5_rpc", redirect_pc, 32'h8000_0100);
    step();
    check("t5_idle", {30'd0, pc_redirect, exl_clr}, 32'd0);
    mem_valid = 1; eret = 1; exc_bp = 1; epc_in = 32'h8000_0200; pc_mem = 32'h500;
    step(); clr_in();
    check("t5_bp_flush", {29'd0, flush, exl_clr, pc_redirect}, 32'h4);
    step();
    check("t5_bp_code", {27'd0, exc_code}, 32'd9);
    step();
    check("t5_bp_rpc", redirect_pc, 32'hBFC0_0380);
    step();

    // 6: reset in COMMIT aborts immediately
    mem_valid = 1; exc_sys = 1; pc_mem = 32'h600;
    step(); clr_in(); step();
    check("t6_commit", {31'd0, cause_w}, 32'd1);
    #2 rst = 1;
    #1 check_all_zero("t6_rst");
    step();
    rst = 0;
    step();
    check("t6_no_redir", {30'd0, pc_redirect, stall}, 32'd0);

`ifdef CP0_EXC_DELAY_SLOT_EN
    mem_valid = 1; exc_sys = 1; in_delay_slot = 1; pc_mem = 32'h400;
    step(); clr_in(); step();
    check("ds_epc", epc_p, 32'h3FC);
    check("ds_bd", {31'd0, cause_bd}, 32'd1);
    step(); step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
